// File: rtl/tug_pkg.sv
// Shared types and width helpers for the tug-of-war referee.
package tug_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_PLAY, S_DONE} state_t;
   typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} player_t;

   function automatic int led_width(input int win_dist);
      return 2 * win_dist + 1;
   endfunction

   function automatic int pos_width(input int win_dist);
      return $clog2(win_dist + 1) + 1;
   endfunction

endpackage

// File: rtl/tug_referee_push_edge.sv
// Registered rising-edge detector for one synchronized push line.
module push_edge (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);

   logic in_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_q <= 1'b0;
      else     in_q <= in;
   end

   assign rise = in & ~in_q;

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war round controller: edge requests, token arbitration under lockout,
// round FSM and rope/lamp position. Define TUG_FOUL_EN to make pushes in ARM false starts.
module tug_referee
   import tug_pkg::*;
#(
   parameter  int WIN_DIST   = 4,
   parameter  int ARM_CYCLES = 16,
   parameter  int LOCKOUT    = 2,
   localparam int LED_W      = led_width(WIN_DIST),
   localparam int PW         = pos_width(WIN_DIST)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 push_l,
   input  logic                 push_r,
   output logic                 grant_l,
   output logic                 grant_r,
   output logic signed [PW-1:0] pos,
   output logic [LED_W-1:0]     leds,
   output logic                 playing,
   output logic                 win_l,
   output logic                 win_r
);

   localparam int CW = $clog2(ARM_CYCLES + 1);
   localparam int LW = $clog2(LOCKOUT + 1);

   localparam logic [CW-1:0]        ARM_LOAD  = CW'(ARM_CYCLES);
   localparam logic [LW-1:0]        LOCK_LOAD = LW'(LOCKOUT);
   localparam logic signed [PW-1:0] POS_MAX   = PW'(WIN_DIST);
   localparam logic signed [PW-1:0] POS_MIN   = PW'(-WIN_DIST);

   state_t                 state_q, state_d;
   player_t                winner_q, winner_d;
   player_t                token_q, token_d;
   logic [CW-1:0]          arm_cnt_q, arm_cnt_d;
   logic [LW-1:0]          lock_q, lock_d;
   logic                   pend_l_q, pend_l_d;
   logic                   pend_r_q, pend_r_d;
   logic                   grant_l_q, grant_l_d;
   logic                   grant_r_q, grant_r_d;
   logic signed [PW-1:0]   pos_q, pos_d;
   logic                   req_l, req_r;
   logic                   clr_pos, eff_l, eff_r, take_l;

   push_edge u_edge_l (.clk(clk), .rst(rst), .in(push_l), .rise(req_l));
   push_edge u_edge_r (.clk(clk), .rst(rst), .in(push_r), .rise(req_r));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      winner_d  = winner_q;
      clr_pos   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_ARM;
               arm_cnt_d = ARM_LOAD;
               clr_pos   = 1'b1;
            end
         end
         S_ARM: begin
`ifdef TUG_FOUL_EN
            if (req_l && req_r) begin
               arm_cnt_d = ARM_LOAD;
            end else if (req_l) begin
               state_d  = S_DONE;
               winner_d = RIGHT;
            end else if (req_r) begin
               state_d  = S_DONE;
               winner_d = LEFT;
            end else if (arm_cnt_q == '0) begin
               state_d = S_PLAY;
            end else begin
               arm_cnt_d = arm_cnt_q - CW'(1);
            end
`else
            if (arm_cnt_q == '0) state_d = S_PLAY;
            else                 arm_cnt_d = arm_cnt_q - CW'(1);
`endif
         end
         S_PLAY: begin
            if (pos_q == POS_MIN) begin
               state_d  = S_DONE;
               winner_d = LEFT;
            end else if (pos_q == POS_MAX) begin
               state_d  = S_DONE;
               winner_d = RIGHT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pending bits and lockout only live while PLAY continues; leaving PLAY drops them.
   always_comb begin
      pend_l_d  = 1'b0;
      pend_r_d  = 1'b0;
      lock_d    = '0;
      token_d   = token_q;
      grant_l_d = 1'b0;
      grant_r_d = 1'b0;
      take_l    = 1'b0;
      eff_l     = pend_l_q | req_l;
      eff_r     = pend_r_q | req_r;
      pos_d     = clr_pos ? '0 : pos_q;
      if (state_q == S_PLAY && state_d == S_PLAY) begin
         pend_l_d = eff_l;
         pend_r_d = eff_r;
         if (lock_q != '0) begin
            lock_d = lock_q - LW'(1);
         end else if (eff_l || eff_r) begin
            take_l = eff_l & (~eff_r | (token_q == LEFT));
            if (eff_l && eff_r) token_d = (token_q == LEFT) ? RIGHT : LEFT;
            lock_d = LOCK_LOAD;
            if (take_l) begin
               grant_l_d = 1'b1;
               pend_l_d  = 1'b0;
               pos_d     = pos_q - PW'(1);
            end else begin
               grant_r_d = 1'b1;
               pend_r_d  = 1'b0;
               pos_d     = pos_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_cnt_q <= '0;
         winner_q  <= LEFT;
         token_q   <= LEFT;
         lock_q    <= '0;
         pend_l_q  <= 1'b0;
         pend_r_q  <= 1'b0;
         grant_l_q <= 1'b0;
         grant_r_q <= 1'b0;
         pos_q     <= '0;
      end else begin
         arm_cnt_q <= arm_cnt_d;
         winner_q  <= winner_d;
         token_q   <= token_d;
         lock_q    <= lock_d;
         pend_l_q  <= pend_l_d;
         pend_r_q  <= pend_r_d;
         grant_l_q <= grant_l_d;
         grant_r_q <= grant_r_d;
         pos_q     <= pos_d;
      end
   end

   always_comb begin
      grant_l = grant_l_q;
      grant_r = grant_r_q;
      pos     = pos_q;
      playing = (state_q == S_PLAY);
      win_l   = (state_q == S_DONE) && (winner_q == LEFT);
      win_r   = (state_q == S_DONE) && (winner_q == RIGHT);
      leds    = '0;
      for (int unsigned i = 0; i < LED_W; i++)
         leds[i] = (int'(i) == WIN_DIST + int'(pos_q));
   end

endmodule

// File: tb/tb_tug_referee.sv
// Bench for tug_referee: directed round scenarios plus a randomized run against
// a cycle-level game model. Follows TUG_FOUL_EN the same way the design does.
module tb_tug_referee;

   localparam int WIN  = 4;
   localparam int ARMC = 16;
   localparam int LOCK = 2;
   localparam int LEDW = 2 * WIN + 1;
   localparam int PW   = $clog2(WIN + 1) + 1;
   localparam int VW   = PW + LEDW + 5;

   localparam int PH_IDLE = 0;
   localparam int PH_ARM  = 1;
   localparam int PH_PLAY = 2;
   localparam int PH_DONE = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 push_l;
   logic                 push_r;
   logic                 grant_l;
   logic                 grant_r;
   logic signed [PW-1:0] pos;
   logic [LEDW-1:0]      leds;
   logic                 playing;
   logic                 win_l;
   logic                 win_r;

   int total = 0;
   int bad   = 0;

   // game model state (winner: 0 none, 1 left, 2 right)
   int m_phase, m_arm_left, m_pos, m_winner, m_last_grant, m_cyc;
   bit m_pend_l, m_pend_r, m_tok_left, m_prev_l, m_prev_r, e_gl, e_gr;

   tug_referee #(.WIN_DIST(WIN), .ARM_CYCLES(ARMC), .LOCKOUT(LOCK)) dut (
      .clk(clk), .rst(rst), .start(start), .push_l(push_l), .push_r(push_r),
      .grant_l(grant_l), .grant_r(grant_r), .pos(pos), .leds(leds),
      .playing(playing), .win_l(win_l), .win_r(win_r)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start  = 1'b0;
      push_l = 1'b0;
      push_r = 1'b0;
      rst    = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic go_play(output int n);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (playing !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic model_init();
      m_phase = PH_IDLE; m_arm_left = 0; m_pos = 0; m_winner = 0;
      m_last_grant = -1000; m_cyc = 0;
      m_pend_l = 0; m_pend_r = 0; m_tok_left = 1; m_prev_l = 0; m_prev_r = 0;
      e_gl = 0; e_gr = 0;
   endtask

   task automatic model_step(input bit s, input bit pl, input bit pr);
      bit rl, rr, take_left;
      rl = pl && !m_prev_l;
      rr = pr && !m_prev_r;
      m_prev_l = pl;
      m_prev_r = pr;
      e_gl = 0;
      e_gr = 0;
      case (m_phase)
         PH_IDLE, PH_DONE: begin
            if (s) begin
               m_phase = PH_ARM; m_arm_left = ARMC + 1; m_pos = 0; m_winner = 0;
            end
         end
         PH_ARM: begin
`ifdef TUG_FOUL_EN
            if (rl && rr) begin
               m_arm_left = ARMC + 1;
            end else if (rl || rr) begin
               m_phase = PH_DONE;
               m_winner = rl ? 2 : 1;
            end else
`endif
            begin
               m_arm_left--;
               if (m_arm_left == 0) begin
                  m_phase = PH_PLAY; m_pend_l = 0; m_pend_r = 0; m_last_grant = -1000;
               end
            end
         end
         PH_PLAY: begin
            if (m_pos == -WIN || m_pos == WIN) begin
               m_winner = (m_pos == -WIN) ? 1 : 2;
               m_phase = PH_DONE; m_pend_l = 0; m_pend_r = 0;
            end else begin
               m_pend_l = m_pend_l | rl;
               m_pend_r = m_pend_r | rr;
               if ((m_cyc - m_last_grant >= LOCK) && (m_pend_l || m_pend_r)) begin
                  take_left = m_pend_l && (!m_pend_r || m_tok_left);
                  if (m_pend_l && m_pend_r) m_tok_left = !m_tok_left;
                  if (take_left) begin
                     m_pend_l = 0; m_pos--; e_gl = 1;
                  end else begin
                     m_pend_r = 0; m_pos++; e_gr = 1;
                  end
                  m_last_grant = m_cyc + 1;
               end
            end
         end
         default: m_phase = PH_IDLE;
      endcase
      m_cyc++;
   endtask

   task automatic test_reset();
      start = 0; push_l = 0; push_r = 0;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({grant_l, grant_r, playing, win_l, win_r} !== 5'b0) begin
         $display("FAIL reset_flags got=%b want=00000", {grant_l, grant_r, playing, win_l, win_r});
         bad++;
      end
      total++;
      if ({pos, leds} !== {PW'(0), 9'b000010000}) begin
         $display("FAIL reset_pos got=%h/%b want=0/000010000", pos, leds);
         bad++;
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_arm_timing();
      int n;
      do_reset();
      go_play(n);
      total++;
      if (n != ARMC + 1) begin
         $display("FAIL arm_len got=%0d want=%0d", n, ARMC + 1);
         bad++;
      end
      total++;
      if (leds !== 9'b000010000 || pos !== PW'(0)) begin
         $display("FAIL play_entry_leds got=%b want=000010000", leds);
         bad++;
      end
   endtask

   task automatic test_held_push();
      int n, gl, gr, first;
      do_reset();
      go_play(n);
      gl = 0; gr = 0; first = -1;
      push_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (grant_r === 1'b1) begin
            gr++;
            if (first < 0) first = i;
         end
         if (grant_l === 1'b1) gl++;
      end
      push_r = 1'b0;
      tick();
      total++;
      if (gr != 1 || gl != 0) begin
         $display("FAIL held_grants got=r%0d/l%0d want=r1/l0", gr, gl);
         bad++;
      end
      total++;
      if (first != 0) begin
         $display("FAIL grant_latency got=%0d want=0", first);
         bad++;
      end
      total++;
      if (pos !== PW'(1) || leds !== 9'b000100000) begin
         $display("FAIL held_pos got=%0d/%b want=1/000100000", $signed(pos), leds);
         bad++;
      end
   endtask

   task automatic test_simultaneous();
      int n, il, ir, cl, cr;
      do_reset();
      go_play(n);
      il = -1; ir = -1; cl = 0; cr = 0;
      push_l = 1'b1;
      push_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (grant_l === 1'b1) begin cl++; if (il < 0) il = i; end
         if (grant_r === 1'b1) begin cr++; if (ir < 0) ir = i; end
      end
      push_l = 1'b0;
      push_r = 1'b0;
      total++;
      if (il != 0 || ir != LOCK + 1 || cl != 1 || cr != 1) begin
         $display("FAIL tie_order got=l@%0d r@%0d (%0d,%0d) want=l@0 r@%0d (1,1)", il, ir, cl, cr, LOCK + 1);
         bad++;
      end
      total++;
      if (pos !== PW'(0)) begin
         $display("FAIL tie_pos got=%0d want=0", $signed(pos));
         bad++;
      end
   endtask

   task automatic test_win_restart();
      int n;
      do_reset();
      go_play(n);
      for (int p = 0; p < WIN; p++) begin
         push_r = 1'b1;
         tick();
         push_r = 1'b0;
         repeat (4) tick();
      end
      total++;
      if (pos !== PW'(WIN) || leds !== 9'b100000000) begin
         $display("FAIL win_pos got=%0d/%b want=4/100000000", $signed(pos), leds);
         bad++;
      end
      total++;
      if ({playing, win_l, win_r} !== 3'b001) begin
         $display("FAIL win_flags got=%b want=001", {playing, win_l, win_r});
         bad++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (pos !== PW'(0) || leds !== 9'b000010000 || {playing, win_l, win_r} !== 3'b000) begin
         $display("FAIL restart got=%0d/%b/%b want=0/000010000/000", $signed(pos), leds, {playing, win_l, win_r});
         bad++;
      end
   endtask

   task automatic test_false_start();
      int n;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      push_l = 1'b1;
      tick();
      push_l = 1'b0;
`ifdef TUG_FOUL_EN
      total++;
      if ({playing, win_l, win_r} !== 3'b001) begin
         $display("FAIL foul_win got=%b want=001", {playing, win_l, win_r});
         bad++;
      end
      repeat (ARMC + 4) tick();
      total++;
      if ({playing, win_l, win_r} !== 3'b001) begin
         $display("FAIL foul_hold got=%b want=001", {playing, win_l, win_r});
         bad++;
      end
`else
      n = 3;
      while (playing !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (n != ARMC + 1) begin
         $display("FAIL arm_push_ignored got=%0d want=%0d", n, ARMC + 1);
         bad++;
      end
      total++;
      if ({win_l, win_r} !== 2'b00 || pos !== PW'(0)) begin
         $display("FAIL arm_push_state got=%b/%0d want=00/0", {win_l, win_r}, $signed(pos));
         bad++;
      end
`endif
   endtask

   task automatic test_reset_mid();
      int n, g;
      do_reset();
      go_play(n);
      for (int p = 0; p < 2; p++) begin
         push_l = 1'b1;
         tick();
         push_l = 1'b0;
         repeat (4) tick();
      end
      push_l = 1'b1;
      tick();
      push_l = 1'b0;
      push_r = 1'b1;
      tick();
      total++;
      if (pos !== PW'(-3) || playing !== 1'b1) begin
         $display("FAIL pre_reset_pos got=%0d want=-3", $signed(pos));
         bad++;
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({grant_l, grant_r, playing, win_l, win_r} !== 5'b0 || pos !== PW'(0) || leds !== 9'b000010000) begin
         $display("FAIL async_reset got=%b/%0d/%b want=00000/0/000010000",
                  {grant_l, grant_r, playing, win_l, win_r}, $signed(pos), leds);
         bad++;
      end
      push_r = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      g = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (grant_l === 1'b1 || grant_r === 1'b1 || playing === 1'b1) g++;
      end
      total++;
      if (g != 0) begin
         $display("FAIL post_reset_quiet got=%0d want=0", g);
         bad++;
      end
   endtask

   task automatic test_random();
      logic [VW-1:0]   exp_v, got_v;
      logic [LEDW-1:0] e_leds;
      bit s, pl, pr;
      do_reset();
      model_init();
      for (int k = 0; k < 3000; k++) begin
         s  = ($urandom_range(0, 15) == 0);
         pl = push_l ^ ($urandom_range(0, 2) == 0);
         pr = push_r ^ ($urandom_range(0, 2) == 0);
         start  = s;
         push_l = pl;
         push_r = pr;
         model_step(s, pl, pr);
         tick();
         e_leds = '0;
         e_leds[WIN + m_pos] = 1'b1;
         exp_v = {e_gl, e_gr, PW'(m_pos), e_leds, m_phase == PH_PLAY,
                  m_phase == PH_DONE && m_winner == 1, m_phase == PH_DONE && m_winner == 2};
         got_v = {grant_l, grant_r, pos, leds, playing, win_l, win_r};
         total++;
         if (got_v !== exp_v) begin
            $display("FAIL random cyc=%0d got=%b want=%b", k, got_v, exp_v);
            bad++;
         end
      end
      start  = 1'b0;
      push_l = 1'b0;
      push_r = 1'b0;
   endtask

   initial begin
      test_reset();
      test_arm_timing();
      test_held_push();
      test_simultaneous();
      test_win_restart();
      test_false_start();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
